// File: rtl/jk_reg_bank_pkg.sv
// Shared types and constants for the jk_reg_bank register bank.
// Mode encoding is common to the bank, its per-bit cell and the bus interface.
package jk_reg_bank_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    MODE_JK  = 2'd0,
    MODE_D   = 2'd1,
    MODE_T   = 2'd2,
    MODE_CNT = 2'd3
  } mode_t;

  // Single-bit up/down request decode for counter mode: only one of j/k may ask.
  function automatic logic cnt_up_req(input logic j0, input logic k0);
    return j0 & ~k0;
  endfunction

  function automatic logic cnt_dn_req(input logic j0, input logic k0);
    return ~j0 & k0;
  endfunction

endpackage

// File: rtl/jk_reg_bank_if.sv
// Control/data bus of jk_reg_bank; the bank is the slave, the driver is the master.
// When JK_REG_BANK_PRESET_EN is defined the bus also carries the pre (preset) strobe.
interface jk_reg_bank_if
  import jk_reg_bank_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic             en;
  mode_t            mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
`ifdef JK_REG_BANK_PRESET_EN
  logic             pre;
`endif
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] chg;
  logic             wrap;

`ifdef JK_REG_BANK_PRESET_EN
  modport master (output en, mode, j, k, pre, input q, qn, chg, wrap);
  modport slave  (input en, mode, j, k, pre, output q, qn, chg, wrap);
`else
  modport master (output en, mode, j, k, input q, qn, chg, wrap);
  modport slave  (input en, mode, j, k, output q, qn, chg, wrap);
`endif

endinterface

// File: rtl/jk_reg_bank_cell.sv
// jk_cell: combinational next-state function of one bank bit for JK, D and T modes.
// Counter mode is resolved in the bank itself, so the cell simply holds there.
module jk_cell
  import jk_reg_bank_pkg::*;
(
  input  logic  i_q,
  input  logic  i_j,
  input  logic  i_k,
  input  mode_t i_mode,
  output logic  o_q_next
);

  always_comb begin
    o_q_next = i_q;
    case (i_mode)
      MODE_JK: begin
        case ({i_j, i_k})
          2'b01:   o_q_next = 1'b0;
          2'b10:   o_q_next = 1'b1;
          2'b11:   o_q_next = ~i_q;
          default: o_q_next = i_q;
        endcase
      end
      MODE_D:  o_q_next = i_j;
      MODE_T:  o_q_next = i_q ^ i_j;
      default: o_q_next = i_q;
    endcase
  end

endmodule

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH-bit JK/D/T register bank with an up/down counter mode and wrap flag.
// Optional synchronous preset (pre) is built when JK_REG_BANK_PRESET_EN is defined.
module jk_reg_bank
  import jk_reg_bank_pkg::*;
#(
  parameter int WIDTH = 4
)(
  input  logic clk,
  input  logic clr,
  jk_reg_bank_if.slave bus
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_chg;
  logic             r_wrap;

  logic [WIDTH-1:0] w_cell_next;
  logic [WIDTH-1:0] w_cnt_inc;
  logic [WIDTH-1:0] w_cnt_dec;
  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap_next;
  logic             w_up;
  logic             w_dn;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .i_q      (r_q[gi]),
      .i_j      (bus.j[gi]),
      .i_k      (bus.k[gi]),
      .i_mode   (bus.mode),
      .o_q_next (w_cell_next[gi])
    );
  end

  assign w_up      = cnt_up_req(bus.j[0], bus.k[0]);
  assign w_dn      = cnt_dn_req(bus.j[0], bus.k[0]);
  assign w_cnt_inc = r_q + WIDTH'(1);
  assign w_cnt_dec = r_q - WIDTH'(1);

  always_comb begin
    w_q_next    = r_q;
    w_wrap_next = 1'b0;
`ifdef JK_REG_BANK_PRESET_EN
    if (bus.pre) begin
      w_q_next = '1;
    end else
`endif
    if (bus.en) begin
      if (bus.mode == MODE_CNT) begin
        // Wrap is detected from the pre-step value: all ones going up, zero going down.
        if (w_up) begin
          w_q_next    = w_cnt_inc;
          w_wrap_next = &r_q;
        end else if (w_dn) begin
          w_q_next    = w_cnt_dec;
          w_wrap_next = ~|r_q;
        end
      end else begin
        w_q_next = w_cell_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q    <= '0;
      r_chg  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_chg  <= w_q_next ^ r_q;
      r_wrap <= w_wrap_next;
    end
  end

  assign bus.q    = r_q;
  assign bus.qn   = ~r_q;
  assign bus.chg  = r_chg;
  assign bus.wrap = r_wrap;

endmodule

// File: doc/jk_reg_bank.md
# jk_reg_bank

Parametrised, multi-mode register bank generalising the single JK flip-flop to WIDTH bits. Each bit follows JK, D or T semantics selected by a shared mode input. A fourth mode runs the bank as an up/down binary counter with a wrap flag. The block is the team's general-purpose state element for small controllers and counters, and the `jk_cell` primitive inside it replaces standalone flip-flop instances.

## Interface
Parameters:
- WIDTH, 4, number of bits in the bank (1..32)

Ports:
- clk  input  1  clock; all state updates on rising edge
- clr  input  1  synchronous, active-high reset; highest priority
- en  input  1  update enable; when 0, all state holds (chg/wrap still clear)
- mode  input  2  0=JK, 1=D, 2=T, 3=CNT
- j  input  WIDTH  per-bit J (D data in mode 1, toggle mask in mode 2, bit 0 = up request in mode 3)
- k  input  WIDTH  per-bit K (ignored in modes 1–2, bit 0 = down request in mode 3)
- q  output  WIDTH  registered state
- qn  output  WIDTH  ~q, combinational from q
- chg  output  WIDTH  registered; bit i = 1 when q[i] changed at the last edge
- wrap  output  1  registered; 1 when the last edge wrapped the counter in CNT mode

## Operation
- Reset: when clr=1 at a rising edge, q=0, chg=0 and wrap=0, so qn becomes all ones. clr overrides en, mode, j and k.
- When en=0 and clr=0: q holds, chg=0, wrap=0.
- Mode JK, per bit: j=0,k=0 hold; j=0,k=1 clear; j=1,k=0 set; j=1,k=1 toggle.
- Mode D: q <= j; k is ignored.
- Mode T: q <= q ^ j; k is ignored.
- Mode CNT: the count is q, treated as unsigned and taken modulo 2^WIDTH.
  - j[0]=1, k[0]=0: count up by 1.
  - j[0]=0, k[0]=1: count down by 1.
  - j[0]=k[0]: hold.
  - j[WIDTH-1:1] and k[WIDTH-1:1] are ignored.
- wrap = 1 for exactly one cycle after an up step from all ones to 0, or a down step from 0 to all ones. In every other case wrap = 0.
- chg = q_next ^ q_current, registered at the same edge as q. chg is 0 after reset, during hold, and on edges where clr=1.
- A mode change takes effect at the edge where the new mode is sampled. No state is kept per mode.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on q, chg and wrap after edge N.
- qn has no additional latency relative to q.
- No handshake. Inputs must be stable around the rising edge of clk.
- If clr is asserted mid-count, the count is lost. The next enabled CNT up step yields 1.
- Simultaneous clr and `pre` (when configured): clr wins.

## Configuration
- Macro: JK_REG_BANK_PRESET_EN.
- Defined: adds input port pre (1 bit), a synchronous active-high preset.
  - When pre=1 and clr=0, q is set to all ones at the edge.
  - chg reflects the bits that changed.
  - wrap = 0.
  - Priority is clr > pre > en/mode.
- Undefined: no pre port. Behaviour is exactly as in Operation.

## Structure
- Package jk_reg_bank_pkg holds:
  - typedef for the 2-bit mode, with constants MODE_JK, MODE_D, MODE_T, MODE_CNT
  - a WIDTH-independent max constant, MAX_WIDTH = 32
- Sub-module jk_cell is a combinational next-state function for one bit: inputs q, j, k, mode; output q_next. It is instantiated WIDTH times and used for modes JK, D and T.
- The CNT path (adder/subtractor and wrap detection) and the chg/wrap registers live in the top module.

## Test plan
All scenarios use WIDTH=4.
- Reset: drive clr=1 for 1 edge with random j, k, mode → q=0000, qn=1111, chg=0000, wrap=0.
- JK mode with en=1, from q=0000, run three edges:
  - j=0011, k=0000 → q=0011, chg=0011.
  - Then j=0101, k=0110 → q=0101: bit 0 set (holds at 1), bit 1 cleared, bit 2 toggled from 0 to 1, bit 3 held. chg=0110.
  - Then j=0000, k=0000 → q=0101, chg=0000.
- D mode then T mode:
  - D mode, j=1010 → q=1010.
  - Then T mode, j=1111 → q=0101, chg=1111.
  - Then en=0 → q holds at 0101, chg=0000.
- CNT wrap:
  - From q=1110, up twice → q=1111 with wrap=0, then q=0000 with wrap=1.
  - Then down once → q=1111 with wrap=1.
  - Then j[0]=k[0]=1 → hold, wrap=0.
- Reset mid-count: count up to q=0110, then assert clr together with an up request → q=0000. The next up step gives q=0001.
- With JK_REG_BANK_PRESET_EN defined:
  - pre=1 from q=0101 → q=1111, chg=1010.
  - clr=1 with pre=1 → q=0000.
